// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative HI/LO multiply/divide unit for the MIPS datapath. It runs
// MULT/MULTU with a shift-add multiplier and DIV/DIVU with a restoring
// divider. Both work on operand magnitudes, and a final FIX cycle applies
// the sign correction. The unit owns the architectural HI/LO registers and
// also services MTHI/MTLO writes.
//
// Optional build macro:
//   EARLY_TERM_EN - when defined, a multiply leaves the iteration loop as
//                   soon as the remaining multiplier bits are all zero. It
//                   always runs at least one step. Results are identical;
//                   only multiply latency changes. Divide is unaffected.
//
// Ports:
//   CLK          rising-edge clock
//   RESET        asynchronous active-low reset
//   start        request strobe (sampled on rising CLK)
//   FuncCode     R-type function: 24 MULT, 25 MULTU, 26 DIV, 27 DIVU,
//                17 MTHI, 19 MTLO
//   A, B         rs / rt operands
//   flush        synchronous abort of an in-flight operation
//   busy         operation in progress
//   done         one-cycle completion pulse
//   div_by_zero  pulses with done when DIV/DIVU had B == 0
//   HI, LO       architectural HI/LO registers
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [5:0]       FuncCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [5:0] FC_MTHI  = 6'd17;
    localparam logic [5:0] FC_MTLO  = 6'd19;
    localparam logic [5:0] FC_MULT  = 6'd24;
    localparam logic [5:0] FC_MULTU = 6'd25;
    localparam logic [5:0] FC_DIV   = 6'd26;
    localparam logic [5:0] FC_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Two's-complement negate of a WIDTH-bit value when en is set.
    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v,
                                                input logic en);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negate of a 2*WIDTH-bit value when en is set.
    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v,
                                                   input logic en);
        logic [2*WIDTH-1:0] r;
        if (en) begin
            r = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;

    // MUL: acc_r is the running product and mcand_r is the multiplicand,
    //      shifted left one place per step. mplier_r holds the remaining
    //      multiplier bits, shifted right one place per step.
    // DIV: acc_r is {remainder, dividend/quotient}. The quotient bits shift
    //      in from the bottom as the dividend bits shift out of the top.
    //      mcand_r[WIDTH-1:0] holds the divisor.
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      cnt_r;
    logic               op_mul_r;
    logic               q_neg_r;
    logic               r_neg_r;
    logic               dz_flag_r;

    logic               busy_r;
    logic               done_r;
    logic               dz_out_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               is_mul_s;
    logic               is_div_s;
    logic               is_signed_s;
    logic               idle_req_s;
    logic               accept_s;
    logic               mt_hi_s;
    logic               mt_lo_s;
    logic               b_zero_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;

    logic [2*WIDTH-1:0] mul_add_s;
    logic [2*WIDTH-1:0] mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic               div_ok_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic [2*WIDTH-1:0] div_step_s;
    logic               count_end_s;
    logic               mul_last_s;

    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   dz_hi_s;

    // Request decode and operand magnitudes.
    always_comb begin
        is_mul_s    = (FuncCode == FC_MULT) || (FuncCode == FC_MULTU);
        is_div_s    = (FuncCode == FC_DIV)  || (FuncCode == FC_DIVU);
        is_signed_s = (FuncCode == FC_MULT) || (FuncCode == FC_DIV);
        // A flush in the same cycle drops any request.
        idle_req_s  = start && !flush && (state_r == ST_IDLE);
        accept_s    = idle_req_s && (is_mul_s || is_div_s);
        mt_hi_s     = idle_req_s && (FuncCode == FC_MTHI);
        mt_lo_s     = idle_req_s && (FuncCode == FC_MTLO);
        b_zero_s    = (B == {WIDTH{1'b0}});
        // The magnitude of the most negative value is its unsigned pattern,
        // so no extra bit is needed.
        mag_a_s     = cneg_w(A, is_signed_s && A[WIDTH-1]);
        mag_b_s     = cneg_w(B, is_signed_s && B[WIDTH-1]);
    end

    // One multiply step and one restoring-divide step.
    always_comb begin
        if (mplier_r[0]) begin
            mul_add_s = mcand_r;
        end else begin
            mul_add_s = {(2*WIDTH){1'b0}};
        end
        mul_sum_s = acc_r + mul_add_s;

        // The remainder is always below the divisor, so the shifted
        // remainder fits in WIDTH+1 bits. The top bit of the difference
        // is then a reliable borrow flag.
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mcand_r[WIDTH-1:0]};
        div_ok_s    = ~div_diff_s[WIDTH];
        if (div_ok_s) begin
            div_rem_s = div_diff_s[WIDTH-1:0];
        end else begin
            div_rem_s = div_shift_s[WIDTH-1:0];
        end
        div_step_s = {div_rem_s, acc_r[WIDTH-2:0], div_ok_s};

        count_end_s = (cnt_r == LAST_CNT);
`ifdef EARLY_TERM_EN
        // Bit 0 is consumed by the current step, so the loop can stop once
        // the remaining bits above it are all zero.
        mul_last_s = count_end_s || (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
        mul_last_s = count_end_s;
`endif
    end

    // Sign-corrected results presented during the FIX cycle.
    always_comb begin
        prod_fix_s = cneg_2w(acc_r, q_neg_r);
        quo_fix_s  = cneg_w(acc_r[WIDTH-1:0], q_neg_r);
        rem_fix_s  = cneg_w(acc_r[2*WIDTH-1:WIDTH], r_neg_r);
        // For divide-by-zero, the low half still holds |A|. Re-applying
        // the dividend sign gives back the original A.
        dz_hi_s    = cneg_w(acc_r[WIDTH-1:0], r_neg_r);
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!accept_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (is_mul_s) begin
                        state_nxt_s = ST_MUL;
                    end else if (b_zero_s) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end
                ST_MUL: begin
                    if (mul_last_s) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (count_end_s) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end
                ST_FIX:  state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc_r     <= {(2*WIDTH){1'b0}};
            mcand_r   <= {(2*WIDTH){1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            op_mul_r  <= 1'b0;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            dz_flag_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_out_r  <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            done_r   <= 1'b0;
            dz_out_r <= 1'b0;
            if (flush) begin
                // Abandon the operation; HI/LO keep their values.
                busy_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            busy_r    <= 1'b1;
                            cnt_r     <= {CW{1'b0}};
                            op_mul_r  <= is_mul_s;
                            q_neg_r   <= is_signed_s && (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_neg_r   <= is_signed_s && A[WIDTH-1];
                            dz_flag_r <= is_div_s && b_zero_s;
                            if (is_mul_s) begin
                                acc_r    <= {(2*WIDTH){1'b0}};
                                mcand_r  <= {{WIDTH{1'b0}}, mag_a_s};
                                mplier_r <= mag_b_s;
                            end else begin
                                acc_r    <= {{WIDTH{1'b0}}, mag_a_s};
                                mcand_r  <= {{WIDTH{1'b0}}, mag_b_s};
                                mplier_r <= {WIDTH{1'b0}};
                            end
                        end else if (mt_hi_s) begin
                            hi_r <= A;
                        end else if (mt_lo_s) begin
                            lo_r <= A;
                        end else begin
                            busy_r <= 1'b0;
                        end
                    end
                    ST_MUL: begin
                        acc_r    <= mul_sum_s;
                        mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                        cnt_r    <= cnt_r + CW'(1);
                    end
                    ST_DIV: begin
                        acc_r <= div_step_s;
                        cnt_r <= cnt_r + CW'(1);
                    end
                    ST_FIX: begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        if (dz_flag_r) begin
                            dz_out_r <= 1'b1;
                            hi_r     <= dz_hi_s;
                            lo_r     <= {WIDTH{1'b1}};
                        end else if (op_mul_r) begin
                            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                            lo_r <= prod_fix_s[WIDTH-1:0];
                        end else begin
                            hi_r <= rem_fix_s;
                            lo_r <= quo_fix_s;
                        end
                    end
                    default: begin
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dz_out_r;
    assign HI          = hi_r;
    assign LO          = lo_r;

endmodule
